// File: rtl/video_write_queue_pkg.sv
// Shared definitions for the video write queue: region codes, deferred-class mask,
// status word layout and the queued entry format.
package video_write_queue_pkg;

   localparam int unsigned DEPTH_DEFAULT = 16;
   localparam int unsigned ENTRY_W       = 68;
   localparam int unsigned LEVEL_W       = 7;
   localparam int unsigned FRAME_W       = 16;

   localparam logic [3:0] REGION_SCROLL   = 4'h0;
   localparam logic [3:0] REGION_ATTR     = 4'h1;
   localparam logic [3:0] REGION_TILE     = 4'h2;
   localparam logic [3:0] REGION_MISC     = 4'h3;
   localparam logic [3:0] REGION_PALETTE  = 4'h4;
   localparam logic [3:0] REGION_SUBPAL   = 4'h5;
   localparam logic [3:0] REGION_VID_LAST = REGION_SUBPAL;
   localparam logic [3:0] REGION_CTRL     = 4'hF;

   // One bit per region; set means the write waits for blanking while deferral is on.
   localparam logic [15:0] DEFER_MASK = 16'h0031;

   // Status word: {frame_count[15:0], 5'b0, level[6:0], vblank, flush_pending, full, empty}
   localparam int unsigned ST_EMPTY     = 0;
   localparam int unsigned ST_FULL      = 1;
   localparam int unsigned ST_FLUSH     = 2;
   localparam int unsigned ST_VBLANK    = 3;
   localparam int unsigned ST_LEVEL_LSB = 4;
   localparam int unsigned ST_FRAME_LSB = 16;

   typedef struct packed {
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } vid_entry_t;

   function automatic logic is_deferred(input logic [3:0] region);
      return DEFER_MASK[region];
   endfunction

endpackage

// File: rtl/video_wq_fifo.sv
// Synchronous FIFO holding queued video writes; head is visible combinationally.
module video_wq_fifo
   import video_write_queue_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  logic [ENTRY_W-1:0] push_data,
   input  logic               pop,
   output logic [ENTRY_W-1:0] head,
   output logic [LEVEL_W-1:0] level,
   output logic               full,
   output logic               empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]     count_q, count_d;
   logic               push_ok, pop_ok;

   assign full    = (count_q == (PTR_W+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign level   = LEVEL_W'(count_q);
   assign head    = mem_q[rd_ptr_q];
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   // Pointers wrap naturally since DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
      count_d  = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/video_write_queue.sv
// CPU-to-video write queue: decodes bus writes, defers palette/scroll/sprite updates
// to vertical blanking, and drains queued writes in order to the video peripheral.
module video_write_queue
   import video_write_queue_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        iomem_valid,
   output logic        iomem_ready,
   input  logic [3:0]  iomem_wstrb,
   input  logic [31:0] iomem_addr,
   input  logic [31:0] iomem_wdata,
   output logic [31:0] iomem_rdata,
   input  logic        vblank,
   output logic        vid_valid,
   output logic [3:0]  vid_wstrb,
   output logic [31:0] vid_addr,
   output logic [31:0] vid_wdata
);

   logic               ready_q, ready_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               defer_en_q, defer_en_d;
   logic               flush_q, flush_d;
   logic               vblank_q;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic               vid_valid_q, vid_valid_d;
   vid_entry_t         vid_q, vid_d;

   vid_entry_t         wr_entry, head_e;
   logic [LEVEL_W-1:0] fifo_level, level_next;
   logic               fifo_full, fifo_empty;
   logic               req, is_write, is_video, ctrl_hit, enq, deq;
   logic [3:0]         region;
   logic [31:0]        status;

   assign wr_entry = '{wstrb: iomem_wstrb, addr: iomem_addr, wdata: iomem_wdata};

   video_wq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (enq),
      .push_data (wr_entry),
      .pop       (deq),
      .head      (head_e),
      .level     (fifo_level),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      region   = iomem_addr[23:20];
      req      = iomem_valid & ~ready_q;
      is_write = |iomem_wstrb;
      is_video = (region <= REGION_VID_LAST);
      ctrl_hit = req & is_write & (region == REGION_CTRL)
                 & (iomem_addr[19:2] == '0) & iomem_wstrb[0];
      enq      = req & is_write & is_video & ~fifo_full;
      // A stalled deferred head blocks everything behind it.
      deq      = ~fifo_empty & (~is_deferred(head_e.addr[23:20]) | ~defer_en_q
                                | vblank | flush_q);
      status   = {frame_q, 5'b0, fifo_level, vblank, flush_q, fifo_full, fifo_empty};

      // Non-video writes are acknowledged and dropped; only a full queue stalls.
      ready_d    = req & ~(is_write & is_video & fifo_full);
      rdata_d    = (req & ~is_write) ? status : '0;
      defer_en_d = ctrl_hit ? iomem_wdata[0] : defer_en_q;

      level_next = fifo_level + LEVEL_W'(enq) - LEVEL_W'(deq);
      flush_d    = flush_q | (ctrl_hit & iomem_wdata[1]);
      if (level_next == '0) flush_d = 1'b0;

      frame_d     = frame_q + FRAME_W'(vblank & ~vblank_q);
      vid_valid_d = deq;
      vid_d       = deq ? head_e : vid_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ready_q     <= 1'b0;
         rdata_q     <= '0;
         defer_en_q  <= 1'b1;
         flush_q     <= 1'b0;
         vblank_q    <= 1'b0;
         frame_q     <= '0;
         vid_valid_q <= 1'b0;
         vid_q       <= '0;
      end else begin
         ready_q     <= ready_d;
         rdata_q     <= rdata_d;
         defer_en_q  <= defer_en_d;
         flush_q     <= flush_d;
         vblank_q    <= vblank;
         frame_q     <= frame_d;
         vid_valid_q <= vid_valid_d;
         vid_q       <= vid_d;
      end
   end

   assign iomem_ready = ready_q;
   assign iomem_rdata = rdata_q;
   assign vid_valid   = vid_valid_q;
   assign vid_wstrb   = vid_q.wstrb;
   assign vid_addr    = vid_q.addr;
   assign vid_wdata   = vid_q.wdata;

endmodule

// File: tb/tb_video_write_queue.sv
// Self-checking bench for video_write_queue: vector table plus corner sequences,
// with a scoreboard of expected video writes checked whenever vid_valid fires.
module tb_video_write_queue;
   import video_write_queue_pkg::*;

   localparam int unsigned DEPTH = 16;

   logic        clk;
   logic        reset;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;
   logic        vblank;
   logic        vid_valid;
   logic [3:0]  vid_wstrb;
   logic [31:0] vid_addr;
   logic [31:0] vid_wdata;

   video_write_queue #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .iomem_valid (iomem_valid),
      .iomem_ready (iomem_ready),
      .iomem_wstrb (iomem_wstrb),
      .iomem_addr  (iomem_addr),
      .iomem_wdata (iomem_wdata),
      .iomem_rdata (iomem_rdata),
      .vblank      (vblank),
      .vid_valid   (vid_valid),
      .vid_wstrb   (vid_wstrb),
      .vid_addr    (vid_addr),
      .vid_wdata   (vid_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int vid_seen = 0;
   vid_entry_t sb[$];

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      bit          queued;
      bit          imm;
   } vec_t;
   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   // One clock: check any drained write at the falling edge, then land #1 after the rise.
   task automatic step();
      vid_entry_t e;
      @(negedge clk);
      if (vid_valid === 1'b1) begin
         vid_seen++;
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL vid_unexpected: got addr 0x%08h data 0x%08h want none", vid_addr, vid_wdata);
         end else begin
            e = sb.pop_front();
            chk("vid_wstrb", 32'(vid_wstrb), 32'(e.wstrb));
            chk("vid_addr", vid_addr, e.addr);
            chk("vid_wdata", vid_wdata, e.wdata);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input bit queued);
      bit ok;
      ok = 1'b0;
      iomem_valid = 1'b1;
      iomem_addr  = a;
      iomem_wdata = d;
      iomem_wstrb = s;
      for (int i = 0; i < 200; i++) begin
         step();
         if (iomem_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      iomem_valid = 1'b0;
      iomem_wstrb = 4'h0;
      chk("wr_ack", 32'(ok), 32'd1);
      if (ok && queued) sb.push_back('{wstrb: s, addr: a, wdata: d});
   endtask

   task automatic bus_read(output logic [31:0] d);
      bit ok;
      ok = 1'b0;
      d = '0;
      iomem_valid = 1'b1;
      iomem_addr  = 32'h00F0_0004;
      iomem_wstrb = 4'h0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (iomem_ready === 1'b1) begin
            ok = 1'b1;
            d = iomem_rdata;
            break;
         end
      end
      iomem_valid = 1'b0;
      chk("rd_ack", 32'(ok), 32'd1);
   endtask

   task automatic vblank_pulse(input int hi);
      vblank = 1'b1;
      repeat (hi) step();
      vblank = 1'b0;
      repeat (2) step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      int          base;
      bit          stalled_ok;
      bit          got;

      vecs[0] = '{32'h0000_0010, 32'h0000_1111, 4'hF, 1'b1, 1'b0};
      vecs[1] = '{32'h0010_0020, 32'h0000_2222, 4'hF, 1'b1, 1'b1};
      vecs[2] = '{32'h0020_0030, 32'h0000_3333, 4'hF, 1'b1, 1'b1};
      vecs[3] = '{32'h0030_0040, 32'h0000_4444, 4'hF, 1'b1, 1'b1};
      vecs[4] = '{32'h0040_0050, 32'h0000_5555, 4'hF, 1'b1, 1'b0};
      vecs[5] = '{32'h0050_0060, 32'h0000_6666, 4'hF, 1'b1, 1'b0};
      vecs[6] = '{32'h0060_0000, 32'h0000_7777, 4'hF, 1'b0, 1'b0};
      vecs[7] = '{32'h00A0_0000, 32'h0000_8888, 4'hF, 1'b0, 1'b0};
      vecs[8] = '{32'h0010_0070, 32'hDEAD_BEEF, 4'h3, 1'b1, 1'b1};

      reset = 1'b1;
      iomem_valid = 1'b0;
      iomem_wstrb = 4'h0;
      iomem_addr  = '0;
      iomem_wdata = '0;
      vblank = 1'b0;
      repeat (3) step();
      reset = 1'b0;
      step();
      chk("rst_ready", 32'(iomem_ready), 32'd0);
      chk("rst_rdata", iomem_rdata, 32'd0);
      chk("rst_vid_valid", 32'(vid_valid), 32'd0);
      chk("rst_vid_wstrb", 32'(vid_wstrb), 32'd0);
      chk("rst_vid_addr", vid_addr, 32'd0);
      chk("rst_vid_wdata", vid_wdata, 32'd0);
      bus_read(rd);
      chk("rst_status", rd, 32'h0000_0001);
      step();
      chk("rdata_idle", iomem_rdata, 32'd0);

      // Table: immediate regions drain right away, deferred wait for blanking.
      for (int v = 0; v < 9; v++) begin
         base = vid_seen;
         bus_write(vecs[v].addr, vecs[v].data, vecs[v].strb, vecs[v].queued);
         step();
         step();
         chk($sformatf("vec%0d_early_drain", v), 32'(vid_seen - base), 32'(vecs[v].imm));
         vblank_pulse(3);
         chk($sformatf("vec%0d_total_drain", v), 32'(vid_seen - base), 32'(vecs[v].queued));
      end
      bus_read(rd);
      chk("vec_status_low", 32'(rd[15:0]), 32'h0001);

      // Deferred write held until vblank; outputs hold afterwards.
      base = vid_seen;
      bus_write(32'h0000_0000, 32'h0000_0005, 4'hF, 1'b1);
      repeat (6) step();
      chk("defer_hold", 32'(vid_seen - base), 32'd0);
      vblank_pulse(3);
      chk("defer_release", 32'(vid_seen - base), 32'd1);
      repeat (3) step();
      chk("idle_vid_valid", 32'(vid_valid), 32'd0);
      chk("idle_hold_addr", vid_addr, 32'h0000_0000);
      chk("idle_hold_wdata", vid_wdata, 32'h0000_0005);

      // Immediate write latency: ready in cycle 1, vid_valid in cycle 2.
      iomem_valid = 1'b1;
      iomem_addr  = 32'h0020_0004;
      iomem_wdata = 32'h0000_A5A5;
      iomem_wstrb = 4'hF;
      step();
      chk("lat_ready", 32'(iomem_ready), 32'd1);
      chk("lat_vid_early", 32'(vid_valid), 32'd0);
      iomem_valid = 1'b0;
      iomem_wstrb = 4'h0;
      sb.push_back('{wstrb: 4'hF, addr: 32'h0020_0004, wdata: 32'h0000_A5A5});
      step();
      chk("lat_vid", 32'(vid_valid), 32'd1);
      repeat (2) step();

      // Deferred head blocks a later immediate write; order preserved.
      base = vid_seen;
      bus_write(32'h0040_0008, 32'h0000_0011, 4'hF, 1'b1);
      bus_write(32'h0020_0010, 32'h0000_0022, 4'hF, 1'b1);
      repeat (6) step();
      chk("block_hold", 32'(vid_seen - base), 32'd0);
      vblank_pulse(4);
      chk("block_release", 32'(vid_seen - base), 32'd2);

      // Flush drains three deferred writes back to back.
      base = vid_seen;
      for (int i = 0; i < 3; i++) bus_write(32'h0050_0000 + 32'(4 * i), 32'h100 + 32'(i), 4'hF, 1'b1);
      repeat (3) step();
      chk("flush_pre", 32'(vid_seen - base), 32'd0);
      bus_write(32'h00F0_0000, 32'h0000_0002, 4'hF, 1'b0);
      repeat (4) step();
      chk("flush_burst", 32'(vid_seen - base), 32'd3);
      bus_read(rd);
      chk("flush_status", 32'(rd[3:0]), 32'h1);
      bus_write(32'h00F0_0000, 32'h0000_0001, 4'hF, 1'b0);

      // Fill to DEPTH, then the next write stalls until a slot frees.
      base = vid_seen;
      for (int i = 0; i < 16; i++) bus_write(32'h0000_0100 + 32'(4 * i), 32'h200 + 32'(i), 4'hF, 1'b1);
      bus_read(rd);
      chk("full_level", 32'(rd[10:4]), 32'd16);
      chk("full_flag", 32'(rd[1:0]), 32'h2);
      iomem_valid = 1'b1;
      iomem_addr  = 32'h0000_0200;
      iomem_wdata = 32'h0000_0299;
      iomem_wstrb = 4'hF;
      stalled_ok = 1'b1;
      repeat (8) begin
         step();
         if (iomem_ready !== 1'b0) stalled_ok = 1'b0;
      end
      chk("full_stall", 32'(stalled_ok), 32'd1);
      vblank = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (iomem_ready === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      chk("full_unstall", 32'(got), 32'd1);
      iomem_valid = 1'b0;
      iomem_wstrb = 4'h0;
      if (got) sb.push_back('{wstrb: 4'hF, addr: 32'h0000_0200, wdata: 32'h0000_0299});
      repeat (24) step();
      vblank = 1'b0;
      repeat (2) step();
      chk("full_drained", 32'(vid_seen - base), 32'd17);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      // Reset with entries queued and a request in flight.
      for (int i = 0; i < 5; i++) bus_write(32'h0000_0300 + 32'(4 * i), 32'h300 + 32'(i), 4'hF, 1'b1);
      bus_read(rd);
      chk("pre_rst_level", 32'(rd[10:4]), 32'd5);
      iomem_valid = 1'b1;
      iomem_addr  = 32'h0020_0400;
      iomem_wdata = 32'h0000_0400;
      iomem_wstrb = 4'hF;
      reset = 1'b1;
      sb.delete();
      step();
      step();
      chk("rst_no_ready", 32'(iomem_ready), 32'd0);
      reset = 1'b0;
      iomem_valid = 1'b0;
      iomem_wstrb = 4'h0;
      step();
      bus_read(rd);
      chk("post_rst_status", rd, 32'h0000_0001);
      for (int i = 0; i < 3; i++) vblank_pulse(2);
      bus_read(rd);
      chk("frame_count", 32'(rd[31:16]), 32'd3);
      chk("post_rst_empty", 32'(rd[15:0]), 32'h0001);
      base = vid_seen;
      bus_write(32'h0000_0500, 32'h0000_0500, 4'hF, 1'b1);
      repeat (4) step();
      chk("rst_defer_en", 32'(vid_seen - base), 32'd0);
      vblank_pulse(3);
      chk("rst_defer_drain", 32'(vid_seen - base), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
